ks_vandana_fp_mul_seq: RTL and testbench

//  Iterative IEEE-754 single-precision multiplier, the inverse operation of the fp divider.

---
 rtl/ks_vandana_fp_mul_seq.sv | 98 +++++++++
 tb/tb_ks_vandana_fp_mul_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ks_vandana_fp_mul_seq.sv
// Iterative IEEE-754 single multiplier: shift-add mantissa product, RADIX_BITS multiplier bits per cycle.
// Result in 24/RADIX_BITS+1 cycles (1 for a zero operand); holds c in DONE until out_ready.
module ks_vandana_fp_mul_seq #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] c,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int STEPS = 24 / RADIX_BITS;
  localparam logic [4:0] LAST = 5'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t      state, state_nx;
  logic        s_r;
  logic [7:0]  ea_r, eb_r;
  logic        zero_r;
  logic [47:0] ma_sh;
  logic [23:0] mb_sh;
  logic [47:0] prod;
  logic [4:0]  cnt;

  logic        accept;
  logic        zero_in;
  logic [47:0] pp;
  logic [22:0] mant_nx;
  logic [7:0]  e_nx;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign zero_in   = (a1[30:0] == 31'd0) || (b1[30:0] == 31'd0);

  // ma_sh already carries the R*cnt shift, so each digit product lands in place.
  assign pp      = ma_sh * {{(48-RADIX_BITS){1'b0}}, mb_sh[RADIX_BITS-1:0]};
  assign mant_nx = prod[47] ? prod[46:24] : prod[45:23];
  assign e_nx    = ea_r + eb_r - 8'd127 + {7'd0, prod[47]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = zero_in ? NORM : MUL;
      MUL:  if (cnt == LAST) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_r    <= 1'b0;
      ea_r   <= 8'd0;
      eb_r   <= 8'd0;
      zero_r <= 1'b0;
      ma_sh  <= 48'd0;
      mb_sh  <= 24'd0;
      prod   <= 48'd0;
      cnt    <= 5'd0;
      c      <= 32'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          s_r    <= a1[31] ^ b1[31];
          ea_r   <= a1[30:23];
          eb_r   <= b1[30:23];
          zero_r <= zero_in;
          ma_sh  <= {24'd0, 1'b1, a1[22:0]};
          mb_sh  <= {1'b1, b1[22:0]};
          prod   <= 48'd0;
          cnt    <= 5'd0;
        end
        MUL: begin
          prod  <= prod + pp;
          ma_sh <= ma_sh << RADIX_BITS;
          mb_sh <= mb_sh >> RADIX_BITS;
          cnt   <= cnt + 5'd1;
        end
        NORM: c <= zero_r ? {s_r, 31'd0} : {s_r, e_nx, mant_nx};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ks_vandana_fp_mul_seq.sv
// Bench for ks_vandana_fp_mul_seq: three radix variants share one stimulus stream,
// each checked against a scoreboard of expected products and latencies.
module tb_ks_vandana_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a1 = 32'd0;
  logic [31:0] b1 = 32'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [31:0] cc [3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] exp_list [$];
  int          acc_list [$];
  bit          zero_list [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [7:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = a[30:23] + b[30:23] - 8'd127;
    if (p[47]) return {s, e + 8'd1, p[46:24]};
    return {s, e, p[45:23]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int R = (g == 0) ? 1 : ((g == 1) ? 4 : 24);
    int rd = 0;
    bit prev = 1'b0;

    ks_vandana_fp_mul_seq #(.RADIX_BITS(R)) dut (
      .clk(clk), .rst(rst), .a1(a1), .b1(b1), .in_valid(in_valid),
      .in_ready(ir[g]), .c(cc[g]), .out_valid(ov[g]), .out_ready(out_ready)
    );

    always @(negedge clk) begin
      if (rst) begin
        rd = exp_list.size();
        prev = 1'b0;
      end else begin
        if (ov[g] && !prev) begin
          if (rd < exp_list.size())
            check($sformatf("lat_r%0d_%0d", R, rd), 32'(cyc - acc_list[rd]),
                  zero_list[rd] ? 32'd1 : 32'(24 / R + 1));
          else
            check($sformatf("spurious_r%0d", R), 32'(ov[g]), 32'd0);
        end
        if (ov[g] && out_ready) begin
          if (rd < exp_list.size()) begin
            check($sformatf("c_r%0d_%0d", R, rd), cc[g], exp_list[rd]);
            rd++;
          end else begin
            check($sformatf("extra_r%0d", R), 32'(ov[g]), 32'd0);
          end
        end
        prev = ov[g];
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (ir !== 3'b111 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("timeout_idle", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    wait_idle();
    a1 = a;
    b1 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_list.push_back(e);
    acc_list.push_back(cyc);
    zero_list.push_back(a[30:0] == 31'd0 || b[30:0] == 31'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (!(u[0].rd == exp_list.size() && u[1].rd == exp_list.size() &&
             u[2].rd == exp_list.size()) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("timeout_drain", 32'd0, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(ir), 32'h7);
    check({tag, "_out_valid"}, 32'(ov), 32'h0);
    for (int g = 0; g < 3; g++) check($sformatf("%s_c%0d", tag, g), cc[g], 32'd0);
  endtask

  initial begin
    logic [31:0] snap [3];
    logic [31:0] ra, rb;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // basic products, including the sub-2.0 mantissa product and the zero path
    issue(32'h40000000, 32'h40400000, 32'h40C00000);
    issue(32'h3FC00000, 32'h3FC00000, 32'h40100000);
    issue(32'h3FC00000, 32'h40000000, 32'h40400000);
    issue(32'hBF800000, 32'h3F800000, 32'hBF800000);
    issue(32'h80000000, 32'h3F800000, 32'h80000000);
    issue(32'h3F800000, 32'h00000000, 32'h00000000);
    drain();

    // backpressure: result held, in_ready low, new operands ignored
    out_ready = 1'b0;
    issue(32'h40000000, 32'h3FC00000, 32'h40400000);
    n = 0;
    while (ov !== 3'b111 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("timeout_bp", 32'd0, 32'd1);
    for (int g = 0; g < 3; g++) snap[g] = cc[g];
    a1 = 32'h41000000;
    b1 = 32'h41000000;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(ov), 32'h7);
      check("bp_in_ready", 32'(ir), 32'h0);
      for (int g = 0; g < 3; g++) check($sformatf("bp_c%0d", g), cc[g], snap[g]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 32'(ov), 32'h0);
    check("bp_release_in_ready", 32'(ir), 32'h7);
    check("bp_c_held", cc[0], 32'h40400000);
    repeat (30) @(posedge clk);
    #1;
    check("bp_no_second_out", 32'(ov), 32'h0);
    drain();

    // reset in the middle of a multiply aborts it
    issue(32'h40000000, 32'h40400000, 32'h40C00000);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("midrst");
    issue(32'h40000000, 32'h40400000, 32'h40C00000);
    drain();

    // random normal operands against the truncating model
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      ra[30:23] = 8'($urandom_range(1, 254));
      rb[30:23] = 8'($urandom_range(1, 254));
      issue(ra, rb, ref_mul(ra, rb));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
